// File: rtl/seq_control_unit_pkg.sv
// Shared types and opcode field definitions for the multi-cycle CPU control unit.
// Imported by the sequencer top and its wait-state timer.
package ccpu_cu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ALU = 3'd1,
    OP_LD  = 3'd2,
    OP_ST  = 3'd3,
    OP_LDI = 3'd4,
    OP_JMP = 3'd5,
    OP_HLT = 3'd6
  } opclass_t;

  // Opcode class match: (ir & MASK) == OPC
  localparam logic [7:0] MASK_ALU = 8'h80, OPC_ALU = 8'h00;
  localparam logic [7:0] MASK_LD  = 8'hF0, OPC_LD  = 8'h80;
  localparam logic [7:0] MASK_ST  = 8'hF0, OPC_ST  = 8'h90;
  localparam logic [7:0] MASK_LDI = 8'hF0, OPC_LDI = 8'hA0;
  localparam logic [7:0] MASK_JMP = 8'hF0, OPC_JMP = 8'hC0;
  localparam logic [7:0] MASK_HLT = 8'hF0, OPC_HLT = 8'hD0;

  localparam int DST_LSB      = 0;
  localparam int SRC_LSB      = 2;
  localparam int ST_SRC_BIT   = 0;
  localparam int FLAG_LSB     = 0;
  localparam int COND_INV_BIT = 2;
  localparam int UNCOND_BIT   = 3;
  localparam int ALU_OP_LSB   = 4;
  localparam int ALU_OP_W     = 3;
  localparam int WCNT_W       = 4;

  function automatic opclass_t decode_class(input logic [7:0] op);
    if ((op & MASK_ALU) == OPC_ALU) return OP_ALU;
    if ((op & MASK_LD)  == OPC_LD)  return OP_LD;
    if ((op & MASK_ST)  == OPC_ST)  return OP_ST;
    if ((op & MASK_LDI) == OPC_LDI) return OP_LDI;
    if ((op & MASK_JMP) == OPC_JMP) return OP_JMP;
    if ((op & MASK_HLT) == OPC_HLT) return OP_HLT;
    return OP_NOP;
  endfunction

  // ss = 0 selects A, which is the ALU's default B input, so no strobe.
  function automatic logic [2:0] src_onehot(input logic [1:0] ss);
    case (ss)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seq_control_unit_wait_timer.sv
// Memory wait-state timer: counts WAIT_STATES extra cycles, then waits for mem_rdy.
// done is the single completion cycle of the current access.
module cu_wait_timer
  import ccpu_cu_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_rdy,
  output logic done
);

  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_STATES);

  logic [WCNT_W-1:0] r_cnt;
  logic              w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT);
  assign done       = active & w_at_limit & mem_rdy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!active || done) begin
      r_cnt <= '0;
    end else if (!w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle FETCH/EXEC/HALT sequencer decoding IR into datapath strobes,
// with fixed memory wait states plus a ready handshake.
module seq_control_unit
  import ccpu_cu_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned NFLAGS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          ir,
  input  logic [NFLAGS-1:0]   flags,
  input  logic                mem_rdy,
  input  logic                resume,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                addr_dp,
  output logic                d_to_di_oe,
  output logic                ir_we,
  output logic                ip_inc,
  output logic                swap_p,
  output logic [3:0]          reg_we,
  output logic [2:0]          alu_src_oe,
  output logic [1:0]          d_src_oe,
  output logic                we_flags,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_oe,
  output logic                halted
);

  state_t   r_state;
  state_t   w_state_nxt;
  opclass_t w_cls;
  logic     w_mem_access;
  logic     w_done;
  logic     w_flag;
  logic [3:0] w_flags_pad;
  logic [3:0] w_dst_oh;
  logic [2:0] w_src_oh;

  assign w_cls    = decode_class(ir);
  assign w_dst_oh = 4'b0001 << ir[DST_LSB +: 2];
  assign w_src_oh = src_onehot(ir[SRC_LSB +: 2]);

  assign w_mem_access = (r_state == ST_FETCH) ||
                        ((r_state == ST_EXEC) &&
                         (w_cls == OP_LD || w_cls == OP_ST || w_cls == OP_LDI));

  // Flags beyond NFLAGS read as 0.
  always_comb begin
    w_flags_pad = '0;
    for (int i = 0; i < int'(NFLAGS); i++) w_flags_pad[i] = flags[i];
  end
  assign w_flag = w_flags_pad[ir[FLAG_LSB +: 2]];

  cu_wait_timer #(.WAIT_STATES(WAIT_STATES)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (w_mem_access),
    .mem_rdy (mem_rdy),
    .done    (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output and the next state get a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    addr_dp     = 1'b0;
    d_to_di_oe  = 1'b0;
    ir_we       = 1'b0;
    ip_inc      = 1'b0;
    swap_p      = 1'b0;
    reg_we      = '0;
    alu_src_oe  = '0;
    d_src_oe    = '0;
    we_flags    = 1'b0;
    alu_op      = '0;
    alu_oe      = 1'b0;
    halted      = 1'b0;

    // Outputs stay quiet for the whole reset pulse, not just until the first edge.
    if (!rst) begin
      alu_op = ir[ALU_OP_LSB +: ALU_OP_W];
      unique case (r_state)
        ST_FETCH: begin
          mem_rd     = 1'b1;
          d_to_di_oe = 1'b1;
          if (w_done) begin
            ir_we       = 1'b1;
            ip_inc      = 1'b1;
            w_state_nxt = ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (w_cls)
            OP_ALU: begin
              alu_oe      = 1'b1;
              alu_src_oe  = w_src_oh;
              reg_we      = w_dst_oh;
              we_flags    = 1'b1;
              w_state_nxt = ST_FETCH;
            end
            OP_LD: begin
              addr_dp    = 1'b1;
              mem_rd     = 1'b1;
              d_to_di_oe = 1'b1;
              if (w_done) begin
                reg_we      = w_dst_oh;
                w_state_nxt = ST_FETCH;
              end
            end
            OP_ST: begin
              addr_dp  = 1'b1;
              mem_wr   = 1'b1;
              d_src_oe = ir[ST_SRC_BIT] ? 2'b10 : 2'b01;
              if (w_done) w_state_nxt = ST_FETCH;
            end
            OP_LDI: begin
              mem_rd     = 1'b1;
              d_to_di_oe = 1'b1;
              if (w_done) begin
                reg_we      = w_dst_oh;
                ip_inc      = 1'b1;
                w_state_nxt = ST_FETCH;
              end
            end
            OP_JMP: begin
              swap_p      = ir[UNCOND_BIT] | (w_flag ^ ir[COND_INV_BIT]);
              w_state_nxt = ST_FETCH;
            end
            OP_HLT:  w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
          endcase
        end

        ST_HALT: begin
          halted = 1'b1;
          if (resume) w_state_nxt = ST_FETCH;
        end

        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: three instances cover WAIT_STATES 0/2 and NFLAGS 4/1.
module tb_seq_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic [3:0] flags4;
  logic [0:0] flags1;
  logic       mem_rdy;
  logic       resume;

  // index 0: WS=0/NF=4, 1: WS=2/NF=4, 2: WS=0/NF=1
  logic [2:0] mem_rd, mem_wr, addr_dp, d_to_di_oe, ir_we, ip_inc, swap_p, we_flags, alu_oe, halted;
  logic [3:0] reg_we     [3];
  logic [2:0] alu_src_oe [3];
  logic [1:0] d_src_oe   [3];
  logic [2:0] alu_op     [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_control_unit #(.WAIT_STATES(0), .NFLAGS(4)) u_ws0 (
    .clk(clk), .rst(rst), .ir(ir), .flags(flags4), .mem_rdy(mem_rdy), .resume(resume),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .addr_dp(addr_dp[0]), .d_to_di_oe(d_to_di_oe[0]),
    .ir_we(ir_we[0]), .ip_inc(ip_inc[0]), .swap_p(swap_p[0]), .reg_we(reg_we[0]),
    .alu_src_oe(alu_src_oe[0]), .d_src_oe(d_src_oe[0]), .we_flags(we_flags[0]),
    .alu_op(alu_op[0]), .alu_oe(alu_oe[0]), .halted(halted[0])
  );

  seq_control_unit #(.WAIT_STATES(2), .NFLAGS(4)) u_ws2 (
    .clk(clk), .rst(rst), .ir(ir), .flags(flags4), .mem_rdy(mem_rdy), .resume(resume),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .addr_dp(addr_dp[1]), .d_to_di_oe(d_to_di_oe[1]),
    .ir_we(ir_we[1]), .ip_inc(ip_inc[1]), .swap_p(swap_p[1]), .reg_we(reg_we[1]),
    .alu_src_oe(alu_src_oe[1]), .d_src_oe(d_src_oe[1]), .we_flags(we_flags[1]),
    .alu_op(alu_op[1]), .alu_oe(alu_oe[1]), .halted(halted[1])
  );

  seq_control_unit #(.WAIT_STATES(0), .NFLAGS(1)) u_nf1 (
    .clk(clk), .rst(rst), .ir(ir), .flags(flags1), .mem_rdy(mem_rdy), .resume(resume),
    .mem_rd(mem_rd[2]), .mem_wr(mem_wr[2]), .addr_dp(addr_dp[2]), .d_to_di_oe(d_to_di_oe[2]),
    .ir_we(ir_we[2]), .ip_inc(ip_inc[2]), .swap_p(swap_p[2]), .reg_we(reg_we[2]),
    .alu_src_oe(alu_src_oe[2]), .d_src_oe(d_src_oe[2]), .we_flags(we_flags[2]),
    .alu_op(alu_op[2]), .alu_oe(alu_oe[2]), .halted(halted[2])
  );

  function automatic logic [17:0] strobes(input int k);
    return {mem_rd[k], mem_wr[k], addr_dp[k], d_to_di_oe[k], ir_we[k], ip_inc[k], swap_p[k],
            reg_we[k], alu_src_oe[k], d_src_oe[k], we_flags[k], alu_oe[k]};
  endfunction

  function automatic logic [21:0] all_outs(input int k);
    return {strobes(k), alu_op[k], halted[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends 1 time unit after a posedge, first FETCH cycle, counter at 0.
  task automatic do_reset(input logic [7:0] op);
    ir = op; flags4 = 4'b0000; flags1 = 1'b0; mem_rdy = 1'b1; resume = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (all_outs(k) !== 22'h0) begin
        $display("FAIL reset_outs[%0d]: got %h want 0", k, all_outs(k)); n_err++;
      end
      n_cmp++;
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'hB0);
    #1;
    if ({mem_rd[0], d_to_di_oe[0], addr_dp[0], halted[0]} !== 4'b1100) begin
      $display("FAIL reset_fetch: got %b want 1100", {mem_rd[0], d_to_di_oe[0], addr_dp[0], halted[0]}); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_alu();
    do_reset(8'h27);
    #1;
    if ({ir_we[0], ip_inc[0], mem_rd[0], addr_dp[0]} !== 4'b1110) begin
      $display("FAIL alu_fetch: got %b want 1110", {ir_we[0], ip_inc[0], mem_rd[0], addr_dp[0]}); n_err++;
    end
    n_cmp++;
    tick(); #1;
    if ({alu_op[0], alu_src_oe[0], reg_we[0], we_flags[0], alu_oe[0], mem_rd[0]} !== 13'b010_001_1000_1_1_0) begin
      $display("FAIL alu_exec: got %b want 0100011000110",
               {alu_op[0], alu_src_oe[0], reg_we[0], we_flags[0], alu_oe[0], mem_rd[0]}); n_err++;
    end
    n_cmp++;
    tick(); #1;
    if (ir_we[0] !== 1'b1) begin
      $display("FAIL alu_refetch: got %b want 1", ir_we[0]); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_ld_wait();
    do_reset(8'h81);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ir_we[1] !== (i == 2)) begin
        $display("FAIL ld_fetch_irwe[%0d]: got %b want %b", i, ir_we[1], (i == 2)); n_err++;
      end
      n_cmp++;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      mem_rdy = (i == 4);
      #1;
      if ({mem_rd[1], addr_dp[1]} !== 2'b11) begin
        $display("FAIL ld_hold[%0d]: got %b want 11", i, {mem_rd[1], addr_dp[1]}); n_err++;
      end
      n_cmp++;
      if (reg_we[1] !== ((i == 4) ? 4'b0010 : 4'b0000)) begin
        $display("FAIL ld_regwe[%0d]: got %b want %b", i, reg_we[1], (i == 4) ? 4'b0010 : 4'b0000); n_err++;
      end
      n_cmp++;
      tick();
    end
    #1;
    if ({mem_rd[1], addr_dp[1]} !== 2'b10) begin
      $display("FAIL ld_back_fetch: got %b want 10", {mem_rd[1], addr_dp[1]}); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_ldi();
    int n_inc = 0;
    do_reset(8'hA0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_inc += int'(ip_inc[0]);
      if (i == 1) begin
        if ({reg_we[0], mem_rd[0], addr_dp[0]} !== 6'b0001_1_0) begin
          $display("FAIL ldi_exec: got %b want 000110", {reg_we[0], mem_rd[0], addr_dp[0]}); n_err++;
        end
        n_cmp++;
      end
      tick();
    end
    if (n_inc !== 2) begin
      $display("FAIL ldi_ipinc_count: got %0d want 2", n_inc); n_err++;
    end
    n_cmp++;
    #1;
    if (ir_we[0] !== 1'b1) begin
      $display("FAIL ldi_refetch: got %b want 1", ir_we[0]); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_jump();
    do_reset(8'hC1);
    flags4 = 4'b0010;
    tick(); #1;
    if (swap_p[0] !== 1'b1) begin
      $display("FAIL jc_taken: got %b want 1", swap_p[0]); n_err++;
    end
    n_cmp++;
    tick(); flags4 = 4'b0000; #1;
    if (swap_p[0] !== 1'b0) begin
      $display("FAIL jc_fetch_noswap: got %b want 0", swap_p[0]); n_err++;
    end
    n_cmp++;
    tick(); #1;
    if (swap_p[0] !== 1'b0) begin
      $display("FAIL jc_not_taken: got %b want 0", swap_p[0]); n_err++;
    end
    n_cmp++;
    tick(); ir = 8'hC5;
    tick(); #1;
    if (swap_p[0] !== 1'b1) begin
      $display("FAIL jc_inverted: got %b want 1", swap_p[0]); n_err++;
    end
    n_cmp++;
    tick(); ir = 8'hC8;
    tick(); #1;
    if (swap_p[0] !== 1'b1) begin
      $display("FAIL jmp_uncond: got %b want 1", swap_p[0]); n_err++;
    end
    n_cmp++;
    do_reset(8'hC3);
    flags4 = 4'b1000; flags1 = 1'b1;
    tick(); #1;
    if ({swap_p[0], swap_p[2]} !== 2'b10) begin
      $display("FAIL jc_flag_range: got %b want 10", {swap_p[0], swap_p[2]}); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_halt();
    do_reset(8'hD0);
    resume = 1'b1;
    tick(); #1;
    if (halted[0] !== 1'b0) begin
      $display("FAIL hlt_exec_halted: got %b want 0", halted[0]); n_err++;
    end
    n_cmp++;
    tick();
    resume = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if ({halted[0], strobes(0)} !== {1'b1, 18'h0}) begin
        $display("FAIL halt_hold[%0d]: got %h want %h", i, {halted[0], strobes(0)}, {1'b1, 18'h0}); n_err++;
      end
      n_cmp++;
      tick();
    end
    resume = 1'b1;
    #1;
    if (halted[0] !== 1'b1) begin
      $display("FAIL halt_resume_cycle: got %b want 1", halted[0]); n_err++;
    end
    n_cmp++;
    tick();
    resume = 1'b0;
    #1;
    if ({mem_rd[0], halted[0]} !== 2'b10) begin
      $display("FAIL halt_to_fetch: got %b want 10", {mem_rd[0], halted[0]}); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_store_nop();
    do_reset(8'h90);
    tick();
    mem_rdy = 1'b0;
    #1;
    if ({mem_wr[0], addr_dp[0], d_src_oe[0], mem_rd[0]} !== 5'b11_01_0) begin
      $display("FAIL st_exec: got %b want 11010", {mem_wr[0], addr_dp[0], d_src_oe[0], mem_rd[0]}); n_err++;
    end
    n_cmp++;
    tick();
    mem_rdy = 1'b1;
    #1;
    if (mem_wr[0] !== 1'b1) begin
      $display("FAIL st_stall_hold: got %b want 1", mem_wr[0]); n_err++;
    end
    n_cmp++;
    tick();
    ir = 8'hB0;
    #1;
    if ({mem_rd[0], mem_wr[0], ir_we[0]} !== 3'b101) begin
      $display("FAIL st_back_fetch: got %b want 101", {mem_rd[0], mem_wr[0], ir_we[0]}); n_err++;
    end
    n_cmp++;
    tick(); #1;
    if (strobes(0) !== 18'h0) begin
      $display("FAIL nop_exec: got %h want 0", strobes(0)); n_err++;
    end
    n_cmp++;
    tick(); #1;
    if (ir_we[0] !== 1'b1) begin
      $display("FAIL nop_refetch: got %b want 1", ir_we[0]); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_st();
    do_reset(8'h91);
    tick(); tick(); tick();
    mem_rdy = 1'b0;
    #1;
    if ({mem_wr[1], addr_dp[1], mem_rd[1], d_src_oe[1]} !== 5'b110_10) begin
      $display("FAIL st_ws2_exec: got %b want 11010", {mem_wr[1], addr_dp[1], mem_rd[1], d_src_oe[1]}); n_err++;
    end
    n_cmp++;
    tick(); tick();
    rst = 1'b1;
    #1;
    if (all_outs(1) !== 22'h0) begin
      $display("FAIL st_reset_outs: got %h want 0", all_outs(1)); n_err++;
    end
    n_cmp++;
    tick(); tick();
    rst = 1'b0;
    mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if ({mem_rd[1], mem_wr[1], ir_we[1]} !== {2'b10, (i == 2)}) begin
        $display("FAIL st_restart_fetch[%0d]: got %b want %b", i, {mem_rd[1], mem_wr[1], ir_we[1]}, {2'b10, (i == 2)}); n_err++;
      end
      n_cmp++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; ir = 8'h00; flags4 = '0; flags1 = '0; mem_rdy = 1'b1; resume = 1'b0;
    test_reset();
    test_alu();
    test_ld_wait();
    test_ldi();
    test_jump();
    test_halt();
    test_store_nop();
    test_reset_mid_st();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
